// File: rtl/count_sequencer_if.sv
// Control/status bundle for count_sequencer: run requests in, count and FSM status out.
// The master modport is the controlling side; the slave modport is the sequencer itself.
interface count_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, limit,
    input  count, state, busy, done
  );

  modport slave (
    input  start, stop, pause, limit,
    output count, state, busy, done
  );
endinterface

// File: rtl/count_sequencer.sv
// Prescaled up-counter sequencer (IDLE/RUN/HOLD/DONE) that counts to a latched limit.
// Define AUTO_RELOAD_EN to restart a run from DONE instead of returning to IDLE.
module count_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input logic               clk,
  input logic               reset,
  count_sequencer_if.slave  bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] lim_q;
  logic [PW-1:0]    presc_q;
  logic             busy_q;
  logic             done_q;

  logic             tick;
  logic [WIDTH-1:0] count_inc;

  assign tick      = (presc_q == PW'(DIV - 1));
  assign count_inc = count_q + WIDTH'(1);

  // Single FSM process; priority is reset > stop > start > pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      lim_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.stop) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            lim_q   <= bus.limit;
            presc_q <= '0;
            count_q <= '0;
            if (bus.limit == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end

        RUN: begin
          // Pause wins over a tick, including the terminal one.
          if (bus.pause) begin
            state_q <= HOLD;
          end else if (tick) begin
            count_q <= count_inc;
            presc_q <= '0;
            if (count_inc == lim_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end

        HOLD: begin
          if (!bus.pause) begin
            state_q <= RUN;
          end
        end

        DONE: begin
`ifdef AUTO_RELOAD_EN
          lim_q   <= bus.limit;
          count_q <= '0;
          presc_q <= '0;
          if (bus.limit == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
`else
          state_q <= IDLE;
          count_q <= '0;
          presc_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
`endif
        end

        default: begin
          state_q <= IDLE;
          count_q <= '0;
          presc_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter DIV, default 1, range 1..16, giving the number of clk cycles per count tick.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a request to begin a count run, sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: an abort request, honoured in every state.
REQ-007 The block SHALL have port pause, input, 1 bit, level-sensitive: it freezes the count while high.
REQ-008 The block SHALL have port limit, input, WIDTH bits: the terminal count, latched on run start.
REQ-009 The block SHALL have port count, output, WIDTH bits: the current count value, registered.
REQ-010 The block SHALL have port state, output, 2 bits, encoded IDLE=00, RUN=01, HOLD=10, DONE=11.
REQ-011 The block SHALL have port busy, output, 1 bit: high when state is RUN or HOLD.
REQ-012 The block SHALL have port done, output, 1 bit: high exactly when state is DONE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, HOLD and DONE; input priority SHALL be reset > stop > start > pause.
REQ-014 In IDLE, start=1 with stop=0 SHALL latch limit into lim_q and clear the prescaler. The next state SHALL be RUN, or DONE if limit==0.
REQ-015 In RUN, a tick SHALL occur on a cycle when prescaler==DIV-1. On a tick, count SHALL increment by 1 and the prescaler SHALL return to 0; otherwise the prescaler SHALL increment.
REQ-016 In RUN, a tick that makes count equal lim_q SHALL move the FSM to DONE on the same edge.
REQ-017 Latency: with DIV=1, start at cycle N SHALL give RUN with count=0 at N+1 and DONE with count=L at N+1+L.
REQ-018 In RUN, pause=1 with no stop SHALL move to HOLD; count and prescaler SHALL freeze, and no tick SHALL occur on that edge.
REQ-019 In HOLD, pause=0 SHALL return to RUN with the prescaler resuming from its frozen value; in HOLD, count and prescaler SHALL not change.
REQ-020 stop=1 in any state SHALL give IDLE with count=0 and prescaler=0 on the next edge; done SHALL not assert for that run.
REQ-021 DONE SHALL last exactly one cycle; its successor SHALL be IDLE with count cleared to 0, except as given in REQ-028.
REQ-022 start SHALL be ignored in RUN, HOLD and DONE; changes to limit SHALL be ignored outside the IDLE start cycle.
REQ-023 count SHALL never wrap, since lim_q is at most 2^WIDTH-1; limit all-ones SHALL count through every value to all-ones.
REQ-024 stop and a terminal tick in the same cycle SHALL resolve to IDLE with no done.
REQ-025 pause and a terminal tick in the same cycle SHALL resolve to HOLD with no increment.

Reset
REQ-026 reset=1 at a clk edge SHALL force state=IDLE, count=0, prescaler=0, lim_q=0, busy=0 and done=0, regardless of other inputs and including mid-run.

Configuration
REQ-027 Macro AUTO_RELOAD_EN SHALL select auto-reload behaviour at compile time.
REQ-028 With AUTO_RELOAD_EN defined, DONE SHALL be followed by RUN with count=0 and prescaler=0, re-latching the current limit; if limit==0, DONE SHALL repeat. stop SHALL remain the only exit besides reset.
REQ-029 Without AUTO_RELOAD_EN, DONE SHALL always be followed by IDLE (one-shot operation).

Verification
REQ-030 Scenario (DIV=1, limit=5): start pulse at cycle 10 -> RUN at 11 with count=0, count=5 and done=1 at 16, IDLE with count=0 at 17.
REQ-031 Scenario (DIV=3, limit=2): start at cycle 0 -> count=1 at cycle 4, DONE at cycle 7, busy high for cycles 1-6.
REQ-032 Scenario (limit=4): pause high for 3 cycles while count=2 -> HOLD for 3 cycles with count held at 2, then done 2 ticks after resume.
REQ-033 Scenario (limit=9): stop at count=6, then separately reset at count=3 -> IDLE with count=0 on the next edge in both cases, done never asserts.
REQ-034 Scenario: limit=0 start -> DONE one cycle later with count=0. Limit=15 (WIDTH=4) -> count reaches 15 without wrap, then DONE.
REQ-035 Scenario (AUTO_RELOAD_EN, limit=2, DIV=1): start -> done pulses every 3 cycles until stop, then IDLE.
